// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: ripples carry/borrow through a register, CHUNK bits per clock,
// least-significant chunk first, with start/busy/done handshake and branch flags.
module seq_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] yr;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic             subr;
   logic             carry;
   logic [CHUNK-1:0] xk;
   logic [CHUNK-1:0] yk;
   logic [CHUNK:0]   sk;

   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             c);
      return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
   endfunction

   // yb is the effective (already inverted for subtract) second operand MSB
   function automatic logic ovf_flag(input logic xm, input logic yb, input logic rm);
      return (xm == yb) && (rm != xm);
   endfunction

   // Subtraction runs as x + ~y + ~bin, so the chain always holds a true add-carry
   always_comb begin
      xk      = xr[int'(cnt)*CHUNK +: CHUNK];
      yk      = yr[int'(cnt)*CHUNK +: CHUNK];
      sk      = chunk_add(xk, yk, carry);
      acc_nxt = acc;
      acc_nxt[int'(cnt)*CHUNK +: CHUNK] = sk[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  xr    <= x;
                  yr    <= sub ? ~y : y;
                  subr  <= sub;
                  carry <= sub ^ cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               carry <= sk[CHUNK];
               if (cnt == LAST) begin
                  // Final chunk: publish result and flags together with done
                  result <= acc_nxt;
                  cout   <= subr ^ sk[CHUNK];
                  ovf    <= ovf_flag(xr[WIDTH-1], yr[WIDTH-1], acc_nxt[WIDTH-1]);
                  zero   <= ~|acc_nxt;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  cnt    <= '0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: three instances (32/8, 32/32, 16/4) driven with directed and
// model-checked vectors; a monitor pops expected responses from per-instance queues on done.
module tb_seq_addsub;

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        o;
      logic        z;
      int          due;
   } exp_t;

   localparam int NV [3] = '{4, 1, 4};
   localparam int WV [3] = '{32, 32, 16};

   logic        clk;
   logic        reset;
   logic [2:0]  start_v, sub_v, cin_v;
   logic [31:0] x_v [3];
   logic [31:0] y_v [3];
   logic [31:0] res_a, res_b;
   logic [15:0] res_c;
   logic [2:0]  cout_v, ovf_v, zero_v, busy_v, done_v;

   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t sbq [3][$];

   seq_addsub #(.WIDTH(32), .CHUNK(8)) u_a (
      .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub_v[0]), .x(x_v[0]), .y(y_v[0]),
      .cin(cin_v[0]), .result(res_a), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]),
      .busy(busy_v[0]), .done(done_v[0]));

   seq_addsub #(.WIDTH(32), .CHUNK(32)) u_b (
      .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub_v[1]), .x(x_v[1]), .y(y_v[1]),
      .cin(cin_v[1]), .result(res_b), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]),
      .busy(busy_v[1]), .done(done_v[1]));

   seq_addsub #(.WIDTH(16), .CHUNK(4)) u_c (
      .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub_v[2]), .x(x_v[2][15:0]),
      .y(y_v[2][15:0]), .cin(cin_v[2]), .result(res_c), .cout(cout_v[2]), .ovf(ovf_v[2]),
      .zero(zero_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] res_of(input int i);
      case (i)
         0:       return res_a;
         1:       return res_b;
         default: return {16'h0, res_c};
      endcase
   endfunction

   function void chk(input string nm, input int inst, input longint act, input longint expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s inst%0d: got %0h, expected %0h (cycle %0d)", nm, inst, act, expv, cyc);
      end
   endfunction

   // Independent reference: full-width integer sum/difference and signed range test
   function automatic void model(input int w, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci, output logic [31:0] r,
                                 output logic c, output logic o, output logic z);
      longint one, m, half, ua, ub, tot, sa, sb, st;
      one  = 1;
      m    = (one << w) - 1;
      half = one << (w - 1);
      ua   = longint'(a) & m;
      ub   = longint'(b) & m;
      tot  = s ? (ua - ub - longint'(ci)) : (ua + ub + longint'(ci));
      r    = 32'(tot & m);
      c    = s ? (tot < 0) : (((tot >> w) & one) != 0);
      sa   = (ua >= half) ? ua - (one << w) : ua;
      sb   = (ub >= half) ? ub - (one << w) : ub;
      st   = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
      o    = (st >= half) || (st < -half);
      z    = (r == 0);
   endfunction

   // Monitor: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (done_v[i]) begin
            if (sbq[i].size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done inst%0d: result=%0h with nothing pending", i, res_of(i));
            end else begin
               e = sbq[i].pop_front();
               chk("result", i, res_of(i), e.r);
               chk("cout",   i, cout_v[i], e.c);
               chk("ovf",    i, ovf_v[i],  e.o);
               chk("zero",   i, zero_v[i], e.z);
               chk("latency_cycle", i, cyc, e.due);
            end
         end
      end
   end

   // Called on a negedge; returns on the negedge after the accepting edge
   task automatic issue(input int i, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [31:0] er, input logic ec, input logic eo,
                        input logic ez);
      exp_t e;
      int   t;
      t = 0;
      while (busy_v[i] && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (t >= 60) chk("idle_timeout", i, 1, 0);
      sub_v[i] = s; x_v[i] = a; y_v[i] = b; cin_v[i] = ci; start_v[i] = 1'b1;
      e.r = er; e.c = ec; e.o = eo; e.z = ez; e.due = cyc + NV[i] + 1;
      sbq[i].push_back(e);
      @(negedge clk);
      start_v[i] = 1'b0;
   endtask

   task automatic issue_model(input int i, input logic s, input logic [31:0] a,
                              input logic [31:0] b, input logic ci);
      logic [31:0] r;
      logic        c, o, z;
      model(WV[i], s, a, b, ci, r, c, o, z);
      issue(i, s, a, b, ci, r, c, o, z);
   endtask

   task automatic wait_drain(input int i);
      int t;
      t = 0;
      while ((sbq[i].size() != 0 || busy_v[i]) && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (t >= 60) chk("drain_timeout", i, 1, 0);
   endtask

   initial begin
      int c0;
      logic [31:0] ra, rb;
      n_cmp = 0; n_bad = 0; cyc = 0;
      reset = 1'b1;
      start_v = 3'b001; sub_v = '0; cin_v = '0;
      for (int i = 0; i < 3; i++) begin x_v[i] = 32'h1234_5678; y_v[i] = 32'h1; end

      // Reset held two cycles with start asserted
      repeat (2) begin
         @(negedge clk);
         chk("reset_flags", 0, {busy_v[0], done_v[0], cout_v[0], ovf_v[0], zero_v[0]}, 0);
         chk("reset_result", 0, res_a, 0);
      end
      start_v = '0;
      reset   = 1'b0;
      @(negedge clk);
      chk("post_reset_busy", 0, busy_v, 0);

      // Directed vectors on the 32/8 instance
      issue(0, 1'b1, 32'h0000_0000, 32'h583b_d1cc, 1'b0, 32'hA7C4_2E34, 1'b1, 1'b0, 1'b0);
      chk("busy_in_run", 0, busy_v[0], 1);
      wait_drain(0);
      issue(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      wait_drain(0);
      issue(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      issue(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      wait_drain(0);
      issue(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      wait_drain(0);

      // start while busy is ignored; result then holds
      issue(0, 1'b0, 32'h1, 32'h2, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);
      start_v[0] = 1'b1; x_v[0] = 32'h100; y_v[0] = 32'h200; sub_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_drain(0);
      repeat (2) begin
         @(negedge clk);
         chk("hold_result", 0, res_a, 32'h3);
      end

      // start held across done: second op accepted in the done cycle, dones 5 apart
      c0 = cyc;
      sub_v[0] = 1'b0; x_v[0] = 32'h10; y_v[0] = 32'h20; cin_v[0] = 1'b0; start_v[0] = 1'b1;
      sbq[0].push_back('{r: 32'h30, c: 1'b0, o: 1'b0, z: 1'b0, due: c0 + 5});
      @(negedge clk);
      sub_v[0] = 1'b1; x_v[0] = 32'h50; y_v[0] = 32'h8;
      sbq[0].push_back('{r: 32'h48, c: 1'b0, o: 1'b0, z: 1'b0, due: c0 + 10});
      repeat (5) @(negedge clk);
      start_v[0] = 1'b0;
      wait_drain(0);

      // Reset during RUN cycle 2 aborts without a done pulse
      sub_v[0] = 1'b0; x_v[0] = 32'h5; y_v[0] = 32'h6; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 0, busy_v[0], 0);
      chk("abort_done", 0, done_v[0], 0);
      chk("abort_result", 0, res_a, 0);
      repeat (8) @(negedge clk);
      issue_model(0, 1'b0, 32'h5, 32'h6, 1'b1);
      wait_drain(0);
      for (int k = 0; k < 4; k++) begin
         ra = $urandom; rb = $urandom;
         issue_model(0, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
      end
      wait_drain(0);

      // Single-cycle instance
      issue(1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      issue(1, 1'b1, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         ra = $urandom; rb = $urandom;
         issue_model(1, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
      end
      wait_drain(1);

      // 16-bit, 4-bit chunk instance
      issue(2, 1'b1, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b1, 1'b0, 1'b0);
      issue(2, 1'b0, 32'h7FFF, 32'h0000, 1'b1, 32'h8000, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         ra = $urandom_range(0, 16'hFFFF); rb = $urandom_range(0, 16'hFFFF);
         issue_model(2, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
      end
      wait_drain(2);

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk("pending_left", i, sbq[i].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
